// File: rtl/rv32_multicycle_core_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32_multicycle_core_if
// Description : Host-side bundle of the multi-cycle RV32I core: run control,
//               instruction-memory load port, debug register read port and
//               architectural status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32_multicycle_core_if #(
    parameter int IMEM_DEPTH = 64
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic            run;
    logic            imem_we;
    logic [AW-1:0]   imem_waddr;
    logic [31:0]     imem_wdata;
    logic [4:0]      dbg_raddr;
    logic [31:0]     dbg_rdata;
    logic [AW+1:0]   pc;
    logic            zero;
    logic            halted;
    logic            error;
    logic [31:0]     instret;

    // Host / testbench side
    modport master (
        output run, imem_we, imem_waddr, imem_wdata, dbg_raddr,
        input  dbg_rdata, pc, zero, halted, error, instret
    );

    // Core side
    modport slave (
        input  run, imem_we, imem_waddr, imem_wdata, dbg_raddr,
        output dbg_rdata, pc, zero, halted, error, instret
    );
endinterface
`default_nettype wire

// File: rtl/rv32_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : rv32_multicycle_core
// Description : Multi-cycle RV32I integer core (R-type ALU, I-type ALU,
//               BEQ/BNE) with internal instruction memory and register file.
//               Each instruction walks FETCH/DECODE/EXECUTE/WRITEBACK; ECALL
//               or an illegal instruction stops the core in HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_multicycle_core #(
    parameter int IMEM_DEPTH = 64,
    parameter int NREG       = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    rv32_multicycle_core_if.slave bus
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int PW = AW + 2;
    localparam int RW = $clog2(NREG);
    localparam logic [PW-1:0] PC_STEP = PW'(4);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [31:0] ECALL    = 32'h0000_0073;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t state, state_next;

    logic [31:0]   imem [IMEM_DEPTH];
    logic [31:0]   regs [NREG];

    logic [31:0]   ir;
    logic [31:0]   reg_a;
    logic [31:0]   reg_b;
    logic [31:0]   imm;
    logic [31:0]   alu_out;
    logic [31:0]   instret;
    logic [PW-1:0] pc;
    logic          zero;
    logic          halted;
    logic          error;

    // Instruction fields
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    // Register index is implemented (matters for the RV32E configuration)
    function automatic logic reg_ok(input logic [4:0] idx);
        return ({27'd0, idx} < NREG);
    endfunction

    logic          is_r;
    logic          is_i;
    logic          is_b;
    logic          is_ecall;
    logic          legal;
    logic [31:0]   imm_i;
    logic [31:0]   imm_b;
    logic [31:0]   rs1_val;
    logic [31:0]   rs2_val;

    // Decode: classify IR, build immediates, read source registers
    always_comb begin
        is_r     = (opcode == OP_R);
        is_i     = (opcode == OP_I);
        is_b     = (opcode == OP_BRANCH);
        is_ecall = (ir == ECALL);
        legal    = 1'b0;
        if (is_r) begin
            legal = ((funct7 == 7'h00) ||
                     (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    && reg_ok(rs1) && reg_ok(rs2) && reg_ok(rd);
        end else if (is_i) begin
            // Shift-immediates must carry a clean funct7 (bit 25 set is not RV32I)
            if (funct3 == 3'b001)
                legal = (funct7 == 7'h00);
            else if (funct3 == 3'b101)
                legal = (funct7 == 7'h00) || (funct7 == 7'h20);
            else
                legal = 1'b1;
            legal = legal && reg_ok(rs1) && reg_ok(rd);
        end else if (is_b) begin
            legal = (funct3 == 3'b000 || funct3 == 3'b001)
                    && reg_ok(rs1) && reg_ok(rs2);
        end
        imm_i   = {{20{ir[31]}}, ir[31:20]};
        imm_b   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        rs1_val = reg_ok(rs1) ? regs[rs1[RW-1:0]] : 32'd0;
        rs2_val = reg_ok(rs2) ? regs[rs2[RW-1:0]] : 32'd0;
    end

    logic [31:0]   alu_b;
    logic [31:0]   alu_res;
    logic [4:0]    shamt;
    logic          alu_zero;
    logic          br_taken;

    // ALU: branches always subtract; funct7[5] only selects SUB for R-type
    always_comb begin
        alu_b   = is_i ? imm : reg_b;
        shamt   = alu_b[4:0];
        alu_res = 32'd0;
        if (is_b) begin
            alu_res = reg_a - alu_b;
        end else begin
            case (funct3)
                3'b000:  alu_res = (is_r && funct7[5]) ? (reg_a - alu_b) : (reg_a + alu_b);
                3'b001:  alu_res = reg_a << shamt;
                3'b010:  alu_res = {31'd0, ($signed(reg_a) < $signed(alu_b))};
                3'b011:  alu_res = {31'd0, (reg_a < alu_b)};
                3'b100:  alu_res = reg_a ^ alu_b;
                3'b101:  alu_res = funct7[5] ? $unsigned($signed(reg_a) >>> shamt)
                                             : (reg_a >> shamt);
                3'b110:  alu_res = reg_a | alu_b;
                default: alu_res = reg_a & alu_b;
            endcase
        end
        alu_zero = (alu_res == 32'd0);
        br_taken = funct3[0] ? !alu_zero : alu_zero;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_HALT: if (bus.run) state_next = S_FETCH;
            S_FETCH:        state_next = S_DECODE;
            S_DECODE:       state_next = (is_ecall || !legal) ? S_HALT : S_EXECUTE;
            S_EXECUTE: begin
                if (!is_b)
                    state_next = S_WRITEBACK;
                else if (br_taken && imm[1])
                    state_next = S_HALT;
                else
                    state_next = S_FETCH;
            end
            S_WRITEBACK:    state_next = S_FETCH;
            default:        state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Instruction memory load port; contents survive reset
    always_ff @(posedge clock) begin
        if (reset && bus.imem_we && (state == S_IDLE || state == S_HALT))
            imem[bus.imem_waddr] <= bus.imem_wdata;
    end

    // Datapath and architectural state
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc      <= '0;
            zero    <= 1'b0;
            halted  <= 1'b0;
            error   <= 1'b0;
            instret <= 32'd0;
            ir      <= 32'd0;
            reg_a   <= 32'd0;
            reg_b   <= 32'd0;
            imm     <= 32'd0;
            alu_out <= 32'd0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (bus.run) begin
                        pc      <= '0;
                        halted  <= 1'b0;
                        error   <= 1'b0;
                        instret <= 32'd0;
                    end
                end
                S_FETCH: begin
                    ir <= imem[pc[PW-1:2]];
                end
                S_DECODE: begin
                    reg_a <= rs1_val;
                    reg_b <= rs2_val;
                    imm   <= is_b ? imm_b : imm_i;
                    if (is_ecall) begin
                        halted <= 1'b1;
                    end else if (!legal) begin
                        halted <= 1'b1;
                        error  <= 1'b1;
                    end
                end
                S_EXECUTE: begin
                    zero <= alu_zero;
                    if (!is_b) begin
                        alu_out <= alu_res;
                    end else if (br_taken && imm[1]) begin
                        // Misaligned target: stop on the branch itself
                        halted <= 1'b1;
                        error  <= 1'b1;
                    end else begin
                        pc      <= br_taken ? (pc + imm[PW-1:0]) : (pc + PC_STEP);
                        instret <= instret + 32'd1;
                    end
                end
                S_WRITEBACK: begin
                    if (rd != 5'd0)
                        regs[rd[RW-1:0]] <= alu_out;
                    pc      <= pc + PC_STEP;
                    instret <= instret + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.dbg_rdata = (reg_ok(bus.dbg_raddr) && bus.dbg_raddr != 5'd0)
                           ? regs[bus.dbg_raddr[RW-1:0]] : 32'd0;
    assign bus.pc        = pc;
    assign bus.zero      = zero;
    assign bus.halted    = halted;
    assign bus.error     = error;
    assign bus.instret   = instret;

endmodule
`default_nettype wire

// File: tb/tb_rv32_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_multicycle_core
// Description : Directed self-checking bench for rv32_multicycle_core
//               (RV32I instance plus an RV32E instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_multicycle_core;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   edges;

    localparam logic [31:0] ECALL = 32'h0000_0073;

    always #5 clock = ~clock;

    rv32_multicycle_core_if #(.IMEM_DEPTH(64)) bus ();
    rv32_multicycle_core_if #(.IMEM_DEPTH(16)) bus16 ();

    rv32_multicycle_core #(.IMEM_DEPTH(64), .NREG(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    rv32_multicycle_core #(.IMEM_DEPTH(16), .NREG(16)) dut16 (
        .clock (clock),
        .reset (reset),
        .bus   (bus16.slave)
    );

    task automatic do_reset();
        @(negedge clock) reset = 1'b0;
        @(negedge clock) reset = 1'b1;
    endtask

    task automatic load(input logic [5:0] addr, input logic [31:0] data);
        @(negedge clock);
        bus.imem_we = 1'b1; bus.imem_waddr = addr; bus.imem_wdata = data;
        @(negedge clock);
        bus.imem_we = 1'b0;
    endtask

    // Edge 0 samples run; returns the edge index at which halted is seen
    task automatic run_until_halt(output int n);
        @(negedge clock) bus.run = 1'b1;
        @(posedge clock); #1 bus.run = 1'b0;
        n = 0;
        while (!bus.halted && n < 400) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        bus.dbg_raddr = 5'd1; #1;
        tests_run++; if (bus.pc !== 8'h00) begin tests_failed++; $display("FAIL rst_pc: got %h expected 00", bus.pc); end
        tests_run++; if (bus.halted !== 1'b0 || bus.error !== 1'b0 || bus.zero !== 1'b0) begin tests_failed++; $display("FAIL rst_flags: got h=%b e=%b z=%b expected 0 0 0", bus.halted, bus.error, bus.zero); end
        tests_run++; if (bus.instret !== 32'd0) begin tests_failed++; $display("FAIL rst_instret: got %0d expected 0", bus.instret); end
        tests_run++; if (bus.dbg_rdata !== 32'd0) begin tests_failed++; $display("FAIL rst_x1: got %h expected 0", bus.dbg_rdata); end
    endtask

    task automatic test_straight_line();
        do_reset();
        load(6'd0, 32'h00500093);   // ADDI x1,x0,5
        load(6'd1, 32'hFFD00113);   // ADDI x2,x0,-3
        load(6'd2, 32'h002081B3);   // ADD  x3,x1,x2
        load(6'd3, ECALL);
        run_until_halt(edges);
        bus.dbg_raddr = 5'd3; #1;
        tests_run++; if (edges !== 14) begin tests_failed++; $display("FAIL sl_cycles: got %0d expected 14", edges); end
        tests_run++; if (bus.dbg_rdata !== 32'd2) begin tests_failed++; $display("FAIL sl_x3: got %h expected 2", bus.dbg_rdata); end
        tests_run++; if (bus.instret !== 32'd3) begin tests_failed++; $display("FAIL sl_instret: got %0d expected 3", bus.instret); end
        tests_run++; if (bus.error !== 1'b0 || bus.zero !== 1'b0) begin tests_failed++; $display("FAIL sl_flags: got e=%b z=%b expected 0 0", bus.error, bus.zero); end
        tests_run++; if (bus.pc !== 8'h0C) begin tests_failed++; $display("FAIL sl_pc: got %h expected 0c", bus.pc); end
    endtask

    task automatic load_loop();
        load(6'd0, 32'h00300093);   // ADDI x1,x0,3
        load(6'd1, 32'hFFF08093);   // ADDI x1,x1,-1
        load(6'd2, 32'hFE009EE3);   // BNE  x1,x0,-4
        load(6'd3, ECALL);
    endtask

    task automatic test_loop();
        do_reset();
        load_loop();
        run_until_halt(edges);
        bus.dbg_raddr = 5'd1; #1;
        tests_run++; if (edges !== 27) begin tests_failed++; $display("FAIL loop_cycles: got %0d expected 27", edges); end
        tests_run++; if (bus.dbg_rdata !== 32'd0) begin tests_failed++; $display("FAIL loop_x1: got %h expected 0", bus.dbg_rdata); end
        tests_run++; if (bus.instret !== 32'd7) begin tests_failed++; $display("FAIL loop_instret: got %0d expected 7", bus.instret); end
        tests_run++; if (bus.zero !== 1'b1 || bus.pc !== 8'h0C) begin tests_failed++; $display("FAIL loop_zero_pc: got z=%b pc=%h expected 1 0c", bus.zero, bus.pc); end
    endtask

    task automatic test_shift_compare();
        logic [31:0] exp_r [6];
        exp_r[0] = 32'd0; exp_r[1] = 32'hFFFFFFF0; exp_r[2] = 32'hFFFFFFFC;
        exp_r[3] = 32'h0000000F; exp_r[4] = 32'd1; exp_r[5] = 32'd1;
        do_reset();
        load(6'd0, 32'hFF000093);   // ADDI x1,x0,-16
        load(6'd1, 32'h4020D113);   // SRAI x2,x1,2
        load(6'd2, 32'h01C0D193);   // SRLI x3,x1,28
        load(6'd3, 32'h00103233);   // SLTU x4,x0,x1
        load(6'd4, 32'h0000A2B3);   // SLT  x5,x1,x0
        load(6'd5, 32'h00700013);   // ADDI x0,x0,7
        load(6'd6, ECALL);
        run_until_halt(edges);
        for (int r = 0; r < 6; r++) begin
            bus.dbg_raddr = 5'(r); #1;
            tests_run++; if (bus.dbg_rdata !== exp_r[r]) begin tests_failed++; $display("FAIL sc_x%0d: got %h expected %h", r, bus.dbg_rdata, exp_r[r]); end
        end
        tests_run++; if (bus.instret !== 32'd6 || bus.pc !== 8'h18 || bus.zero !== 1'b0) begin tests_failed++; $display("FAIL sc_status: got ir=%0d pc=%h z=%b expected 6 18 0", bus.instret, bus.pc, bus.zero); end
    endtask

    task automatic test_logic_ops();
        logic [31:0] exp_r [9];
        exp_r[0] = 32'd0;  exp_r[1] = 32'h000000F0; exp_r[2] = 32'h0000003C;
        exp_r[3] = 32'hCC; exp_r[4] = 32'hFC;       exp_r[5] = 32'h30;
        exp_r[6] = 32'h003C0000; exp_r[7] = 32'd0;  exp_r[8] = 32'd0;
        do_reset();
        load(6'd0, 32'h0F000093);   // ADDI x1,x0,0xF0
        load(6'd1, 32'h03C00113);   // ADDI x2,x0,0x3C
        load(6'd2, 32'h0020C1B3);   // XOR  x3,x1,x2
        load(6'd3, 32'h0020E233);   // OR   x4,x1,x2
        load(6'd4, 32'h0020F2B3);   // AND  x5,x1,x2
        load(6'd5, 32'h00111333);   // SLL  x6,x2,x1
        load(6'd6, 32'h401083B3);   // SUB  x7,x1,x1
        load(6'd7, 32'h02109413);   // SLLI x8,x1,1 with bit 25 set (illegal)
        run_until_halt(edges);
        for (int r = 0; r < 9; r++) begin
            bus.dbg_raddr = 5'(r); #1;
            tests_run++; if (bus.dbg_rdata !== exp_r[r]) begin tests_failed++; $display("FAIL lo_x%0d: got %h expected %h", r, bus.dbg_rdata, exp_r[r]); end
        end
        tests_run++; if (bus.error !== 1'b1 || bus.pc !== 8'h1C || bus.instret !== 32'd7 || bus.zero !== 1'b1) begin tests_failed++; $display("FAIL lo_status: got e=%b pc=%h ir=%0d z=%b expected 1 1c 7 1", bus.error, bus.pc, bus.instret, bus.zero); end
        tests_run++; if (edges !== 30) begin tests_failed++; $display("FAIL lo_cycles: got %0d expected 30", edges); end
    endtask

    task automatic test_branch_misaligned();
        do_reset();
        load(6'd0, 32'h00000163);   // BEQ x0,x0,+2 (taken, misaligned)
        run_until_halt(edges);
        tests_run++; if (edges !== 3) begin tests_failed++; $display("FAIL bm_cycles: got %0d expected 3", edges); end
        tests_run++; if (bus.halted !== 1'b1 || bus.error !== 1'b1 || bus.pc !== 8'h00 || bus.instret !== 32'd0) begin tests_failed++; $display("FAIL bm_status: got h=%b e=%b pc=%h ir=%0d expected 1 1 00 0", bus.halted, bus.error, bus.pc, bus.instret); end
    endtask

    task automatic test_rv32e();
        logic [31:0] p [3];
        p[0] = 32'h00500093;        // ADDI x1,x0,5
        p[1] = 32'hFFD00113;        // ADDI x2,x0,-3
        p[2] = 32'h002088B3;        // ADD  x17,x1,x2
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus16.imem_we = 1'b1; bus16.imem_waddr = 4'(i); bus16.imem_wdata = p[i];
        end
        @(negedge clock) begin bus16.imem_we = 1'b0; bus16.run = 1'b1; end
        @(posedge clock); #1 bus16.run = 1'b0;
        edges = 0;
        while (!bus16.halted && edges < 400) begin @(posedge clock); #1; edges++; end
        bus16.dbg_raddr = 5'd17; #1;
        tests_run++; if (bus16.dbg_rdata !== 32'd0) begin tests_failed++; $display("FAIL e_x17: got %h expected 0", bus16.dbg_rdata); end
        bus16.dbg_raddr = 5'd1; #1;
        tests_run++; if (bus16.dbg_rdata !== 32'd5) begin tests_failed++; $display("FAIL e_x1: got %h expected 5", bus16.dbg_rdata); end
        tests_run++; if (bus16.halted !== 1'b1 || bus16.error !== 1'b1) begin tests_failed++; $display("FAIL e_flags: got h=%b e=%b expected 1 1", bus16.halted, bus16.error); end
        tests_run++; if (bus16.pc !== 6'h08 || bus16.instret !== 32'd2 || edges !== 10) begin tests_failed++; $display("FAIL e_status: got pc=%h ir=%0d cyc=%0d expected 08 2 10", bus16.pc, bus16.instret, edges); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        load_loop();
        @(negedge clock) bus.run = 1'b1;
        @(posedge clock); #1 bus.run = 1'b0;          // edge 0
        repeat (6) @(posedge clock);                   // edge 6: EXECUTE of instr 2
        #1 bus.dbg_raddr = 5'd1;
        #1;
        tests_run++; if (bus.dbg_rdata !== 32'd3 || bus.instret !== 32'd1) begin tests_failed++; $display("FAIL rm_pre: got x1=%h ir=%0d expected 3 1", bus.dbg_rdata, bus.instret); end
        reset = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        tests_run++; if (bus.pc !== 8'h00 || bus.instret !== 32'd0 || bus.dbg_rdata !== 32'd0 || bus.halted !== 1'b0) begin tests_failed++; $display("FAIL rm_post: got pc=%h ir=%0d x1=%h h=%b expected 00 0 0 0", bus.pc, bus.instret, bus.dbg_rdata, bus.halted); end
        run_until_halt(edges);
        tests_run++; if (edges !== 27 || bus.instret !== 32'd7 || bus.dbg_rdata !== 32'd0 || bus.zero !== 1'b1) begin tests_failed++; $display("FAIL rm_rerun: got cyc=%0d ir=%0d x1=%h z=%b expected 27 7 0 1", edges, bus.instret, bus.dbg_rdata, bus.zero); end
    endtask

    task automatic test_load_protection();
        do_reset();
        load_loop();
        @(negedge clock) bus.run = 1'b1;
        @(posedge clock); #1 bus.run = 1'b0;
        @(negedge clock);
        bus.imem_we = 1'b1; bus.imem_waddr = 6'd1; bus.imem_wdata = ECALL;
        repeat (4) @(negedge clock);
        bus.imem_we = 1'b0;
        edges = 0;
        while (!bus.halted && edges < 400) begin @(posedge clock); #1; edges++; end
        bus.dbg_raddr = 5'd1; #1;
        tests_run++; if (bus.dbg_rdata !== 32'd0 || bus.instret !== 32'd7 || bus.error !== 1'b0) begin tests_failed++; $display("FAIL lp_running: got x1=%h ir=%0d e=%b expected 0 7 0", bus.dbg_rdata, bus.instret, bus.error); end
        load(6'd1, ECALL);                             // accepted in HALT
        run_until_halt(edges);
        tests_run++; if (bus.dbg_rdata !== 32'd3 || bus.instret !== 32'd1 || bus.pc !== 8'h04 || edges !== 6) begin tests_failed++; $display("FAIL lp_halt: got x1=%h ir=%0d pc=%h cyc=%0d expected 3 1 04 6", bus.dbg_rdata, bus.instret, bus.pc, edges); end
        // run and write on the same edge: new word is the first fetch
        @(negedge clock);
        bus.run = 1'b1; bus.imem_we = 1'b1; bus.imem_waddr = 6'd0; bus.imem_wdata = ECALL;
        @(posedge clock); #1 begin bus.run = 1'b0; bus.imem_we = 1'b0; end
        edges = 0;
        while (!bus.halted && edges < 400) begin @(posedge clock); #1; edges++; end
        tests_run++; if (edges !== 2 || bus.pc !== 8'h00 || bus.instret !== 32'd0 || bus.error !== 1'b0) begin tests_failed++; $display("FAIL lp_same_edge: got cyc=%0d pc=%h ir=%0d e=%b expected 2 00 0 0", edges, bus.pc, bus.instret, bus.error); end
    endtask

    initial begin
        bus.run = 1'b0; bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0; bus.dbg_raddr = '0;
        bus16.run = 1'b0; bus16.imem_we = 1'b0; bus16.imem_waddr = '0; bus16.imem_wdata = '0; bus16.dbg_raddr = '0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        test_reset();
        test_straight_line();
        test_loop();
        test_shift_compare();
        test_logic_ops();
        test_branch_misaligned();
        test_rv32e();
        test_reset_mid_run();
        test_load_protection();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
